// File: rtl/pooling_pkg.sv
// Shared constants and types for the pooling-layer sequencer.
package pooling_pkg;

  localparam int unsigned K          = 2;
  localparam int unsigned S          = 2;
  localparam int unsigned POOL_UNITS = 4;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DIM_W      = 8;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned PIPE_LAT   = 3;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, ERR, DONE} pool_state_t;

  typedef struct packed {
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] grp;
  } win_coord_t;

  // Number of window positions along one map dimension.
  function automatic logic [DIM_W-1:0] out_dim(input logic [DIM_W-1:0] in_dim);
    return DIM_W'((32'(in_dim) - K) / S + 1);
  endfunction

endpackage

// File: rtl/pooling_ctrl_if.sv
// Window-fetch request and pooled-output write stream of the pooling sequencer.
interface pooling_ctrl_if;
  import pooling_pkg::*;

  logic              win_rd_en;
  logic [DIM_W-1:0]  win_row;
  logic [DIM_W-1:0]  win_col;
  logic [DIM_W-1:0]  win_grp;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ready;

  modport master (
    output win_rd_en, win_row, win_col, win_grp, wr_valid, wr_addr,
    input  wr_ready
  );

  modport slave (
    input  win_rd_en, win_row, win_col, win_grp, wr_valid, wr_addr,
    output wr_ready
  );

endinterface

// File: rtl/pool_scan_counter.sv
// Nested ox/oy/grp raster counters; ox is innermost, grp outermost.
module pool_scan_counter
  import pooling_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIM_W-1:0] ow_i,
  input  logic [DIM_W-1:0] oh_i,
  input  logic [DIM_W-1:0] ng_i,
  output logic [DIM_W-1:0] ox_o,
  output logic [DIM_W-1:0] oy_o,
  output logic [DIM_W-1:0] grp_o,
  output logic             last_o
);

  localparam logic [DIM_W-1:0] One = DIM_W'(1);

  logic [DIM_W-1:0] ox_q, ox_d;
  logic [DIM_W-1:0] oy_q, oy_d;
  logic [DIM_W-1:0] grp_q, grp_d;
  logic             ox_wrap, oy_wrap;

  assign ox_wrap = (ox_q == ow_i - One);
  assign oy_wrap = (oy_q == oh_i - One);

  always_comb begin
    ox_d  = ox_q;
    oy_d  = oy_q;
    grp_d = grp_q;
    if (clr_i) begin
      ox_d  = '0;
      oy_d  = '0;
      grp_d = '0;
    end else if (en_i) begin
      if (ox_wrap) begin
        ox_d = '0;
        if (oy_wrap) begin
          oy_d  = '0;
          grp_d = grp_q + One;
        end else begin
          oy_d = oy_q + One;
        end
      end else begin
        ox_d = ox_q + One;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ox_q  <= '0;
      oy_q  <= '0;
      grp_q <= '0;
    end else begin
      ox_q  <= ox_d;
      oy_q  <= oy_d;
      grp_q <= grp_d;
    end
  end

  assign ox_o   = ox_q;
  assign oy_o   = oy_q;
  assign grp_o  = grp_q;
  assign last_o = ox_wrap & oy_wrap & (grp_q == ng_i - One);

endmodule

// File: rtl/pooling_ctrl.sv
// Sequencer for the pooling layer: scans one job in output raster order, one window per cycle,
// and tracks the fetch/pool pipeline to produce the output write stream.
module pooling_ctrl
  import pooling_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [DIM_W-1:0] map_w,
  input  logic [DIM_W-1:0] map_h,
  input  logic [DIM_W-1:0] num_groups,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             ctrl_pool,
  output logic             in_pipe_en,
  output logic             out_pipe_en,
  pooling_ctrl_if.master   pif
);

  pool_state_t       state_q;
  logic              busy_q, done_q, cfg_err_q, mode_q;
  logic [DIM_W-1:0]  ow_q, oh_q, ng_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic [PIPE_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [PIPE_LAT];

  logic             stall, fetch, accept, cfg_ok, scan_last;
  logic [DIM_W-1:0] ox, oy, grp;
  win_coord_t       win;

  // An unaccepted result at the pipe tail freezes the whole sequencer.
  assign stall  = vld_q[PIPE_LAT-1] & ~pif.wr_ready;
  assign fetch  = (state_q == RUN) & ~stall;
  assign accept = (state_q == IDLE) & start;
  assign cfg_ok = (map_w >= DIM_W'(K)) && (map_h >= DIM_W'(K)) && (num_groups != '0);

  pool_scan_counter u_scan (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (accept),
    .en_i   (fetch),
    .ow_i   (ow_q),
    .oh_i   (oh_q),
    .ng_i   (ng_q),
    .ox_o   (ox),
    .oy_o   (oy),
    .grp_o  (grp),
    .last_o (scan_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      mode_q       <= 1'b1;
      ow_q         <= '0;
      oh_q         <= '0;
      ng_q         <= '0;
      fetch_addr_q <= '0;
      vld_q        <= '0;
      for (int i = 0; i < PIPE_LAT; i++) addr_q[i] <= '0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (!stall) begin
        vld_q     <= {vld_q[PIPE_LAT-2:0], fetch};
        addr_q[0] <= fetch_addr_q;
        for (int i = 1; i < PIPE_LAT; i++) addr_q[i] <= addr_q[i-1];
      end
      if (fetch) fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q       <= 1'b1;
            mode_q       <= mode;
            ow_q         <= out_dim(map_w);
            oh_q         <= out_dim(map_h);
            ng_q         <= num_groups;
            fetch_addr_q <= '0;
            state_q      <= cfg_ok ? RUN : ERR;
          end
        end
        RUN: begin
          if (fetch && scan_last) state_q <= DRAIN;
        end
        DRAIN: begin
          // Last result leaves the tail this cycle and nothing is behind it.
          if (!stall && vld_q[PIPE_LAT-2:0] == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ERR: begin
          state_q   <= IDLE;
          done_q    <= 1'b1;
          cfg_err_q <= 1'b1;
          busy_q    <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign win.row = DIM_W'(oy * S);
  assign win.col = DIM_W'(ox * S);
  assign win.grp = grp;

  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign ctrl_pool     = mode_q;
  assign in_pipe_en    = vld_q[0] & ~stall;
  assign out_pipe_en   = vld_q[1] & ~stall;
  assign pif.win_rd_en = fetch;
  assign pif.win_row   = win.row;
  assign pif.win_col   = win.col;
  assign pif.win_grp   = win.grp;
  assign pif.wr_valid  = vld_q[PIPE_LAT-1];
  assign pif.wr_addr   = addr_q[PIPE_LAT-1];

endmodule

// File: tb/tb_pooling_ctrl.sv
// Directed self-checking bench for pooling_ctrl.
module tb_pooling_ctrl;
  import pooling_pkg::*;

  logic             clk = 1'b0;
  logic             rst, start, mode;
  logic [DIM_W-1:0] map_w, map_h, num_groups;
  logic             busy, done, cfg_err, ctrl_pool, in_pipe_en, out_pipe_en;
  int               checks = 0;
  int               passes = 0;

  pooling_ctrl_if pif ();

  pooling_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .map_w       (map_w),
    .map_h       (map_h),
    .num_groups  (num_groups),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .ctrl_pool   (ctrl_pool),
    .in_pipe_en  (in_pipe_en),
    .out_pipe_en (out_pipe_en),
    .pif         (pif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start pulse this cycle; returns one cycle after start was sampled.
  task automatic launch(input logic m, input logic [DIM_W-1:0] w, input logic [DIM_W-1:0] h,
                        input logic [DIM_W-1:0] g);
    start = 1'b1; mode = m; map_w = w; map_h = h; num_groups = g;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({busy, done, cfg_err, in_pipe_en, out_pipe_en} !== 5'b0)
      $display("FAIL reset_ctl got %b want 00000", {busy, done, cfg_err, in_pipe_en, out_pipe_en});
    else passes++;
    checks++;
    if ({pif.win_rd_en, pif.wr_valid} !== 2'b00)
      $display("FAIL reset_bus got %b want 00", {pif.win_rd_en, pif.wr_valid});
    else passes++;
    checks++;
    if (ctrl_pool !== 1'b1) $display("FAIL reset_ctrl_pool got %b want 1", ctrl_pool);
    else passes++;
    rst = 1'b0;
    step();
    checks++;
    if ({pif.wr_addr, pif.win_row, pif.win_col, busy} !== {ADDR_W'(0), 8'd0, 8'd0, 1'b0})
      $display("FAIL reset_idle got addr=%0d row=%0d col=%0d busy=%b want 0 0 0 0",
               pif.wr_addr, pif.win_row, pif.win_col, busy);
    else passes++;
  endtask

  task automatic test_basic();
    logic [5:0]       exp_flags;
    logic [DIM_W-1:0] exp_row, exp_col;
    launch(1'b1, 8'd4, 8'd4, 8'd1);
    for (int k = 1; k <= 9; k++) begin
      exp_flags = {(k >= 1 && k <= 4), (k >= 2 && k <= 5), (k >= 3 && k <= 6),
                   (k >= 4 && k <= 7), (k >= 1 && k <= 7), (k == 8)};
      checks++;
      if ({pif.win_rd_en, in_pipe_en, out_pipe_en, pif.wr_valid, busy, done} !== exp_flags)
        $display("FAIL basic_flags k=%0d got %b want %b", k,
                 {pif.win_rd_en, in_pipe_en, out_pipe_en, pif.wr_valid, busy, done}, exp_flags);
      else passes++;
      if (exp_flags[5]) begin
        exp_row = DIM_W'(((k - 1) / 2) * 2);
        exp_col = DIM_W'(((k - 1) % 2) * 2);
        checks++;
        if ({pif.win_row, pif.win_col, pif.win_grp} !== {exp_row, exp_col, 8'd0})
          $display("FAIL basic_win k=%0d got (%0d,%0d,%0d) want (%0d,%0d,0)", k,
                   pif.win_row, pif.win_col, pif.win_grp, exp_row, exp_col);
        else passes++;
      end
      if (exp_flags[2]) begin
        checks++;
        if (pif.wr_addr !== ADDR_W'(k - 4))
          $display("FAIL basic_addr k=%0d got %0d want %0d", k, pif.wr_addr, k - 4);
        else passes++;
      end
      step();
    end
    checks++;
    if (ctrl_pool !== 1'b1) $display("FAIL basic_ctrl_pool got %b want 1", ctrl_pool);
    else passes++;
  endtask

  task automatic test_mode_latch();
    int bad = 0;
    launch(1'b0, 8'd4, 8'd4, 8'd1);
    for (int k = 1; k <= 10; k++) begin
      mode = k[0];
      if (ctrl_pool !== 1'b0) bad++;
      step();
    end
    mode = 1'b1;
    checks++;
    if (bad !== 0) $display("FAIL mode_latch got %0d cycles with ctrl_pool!=0 want 0", bad);
    else passes++;
  endtask

  task automatic test_stall();
    int held = 0;
    int nexp = 0;
    int done_k = -1;
    launch(1'b1, 8'd6, 8'd4, 8'd2);
    for (int k = 1; k <= 22; k++) begin
      pif.wr_ready = !(k >= 5 && k <= 7);
      #1;
      if (pif.wr_valid && pif.wr_addr == ADDR_W'(1)) held++;
      if (k >= 5 && k <= 7) begin
        checks++;
        if ({pif.win_rd_en, in_pipe_en, out_pipe_en} !== 3'b000)
          $display("FAIL stall_freeze k=%0d got %b want 000", k,
                   {pif.win_rd_en, in_pipe_en, out_pipe_en});
        else passes++;
      end
      if (pif.wr_valid && pif.wr_ready) begin
        checks++;
        if (pif.wr_addr !== ADDR_W'(nexp))
          $display("FAIL stall_seq got %0d want %0d", pif.wr_addr, nexp);
        else passes++;
        nexp++;
      end
      if (k == 15) begin
        checks++;
        if ({pif.win_rd_en, pif.win_row, pif.win_col, pif.win_grp} !== {1'b1, 8'd2, 8'd4, 8'd1})
          $display("FAIL stall_last_win got en=%b (%0d,%0d,%0d) want 1 (2,4,1)", pif.win_rd_en,
                   pif.win_row, pif.win_col, pif.win_grp);
        else passes++;
      end
      if (done) done_k = k;
      step();
    end
    pif.wr_ready = 1'b1;
    checks++;
    if (held !== 4) $display("FAIL stall_hold got %0d cycles want 4", held);
    else passes++;
    checks++;
    if (nexp !== 12) $display("FAIL stall_count got %0d writes want 12", nexp);
    else passes++;
    checks++;
    if (done_k !== 19) $display("FAIL stall_done got cycle %0d want 19", done_k);
    else passes++;
  endtask

  task automatic test_cfg_err();
    logic fetch_seen = 1'b0;
    launch(1'b1, 8'd1, 8'd4, 8'd1);
    for (int k = 1; k <= 4; k++) begin
      if (pif.win_rd_en) fetch_seen = 1'b1;
      if (k == 1) begin
        checks++;
        if ({busy, done} !== 2'b10) $display("FAIL err_k1 got %b want 10", {busy, done});
        else passes++;
      end
      if (k == 2) begin
        checks++;
        if ({done, cfg_err} !== 2'b11) $display("FAIL err_pulse got %b want 11", {done, cfg_err});
        else passes++;
      end
      if (k == 3) begin
        checks++;
        if ({busy, done, cfg_err} !== 3'b000)
          $display("FAIL err_after got %b want 000", {busy, done, cfg_err});
        else passes++;
      end
      step();
    end
    checks++;
    if (fetch_seen !== 1'b0) $display("FAIL err_nofetch got %b want 0", fetch_seen);
    else passes++;
    launch(1'b1, 8'd4, 8'd4, 8'd0);
    step();
    checks++;
    if ({done, cfg_err, pif.win_rd_en} !== 3'b110)
      $display("FAIL err_groups got %b want 110", {done, cfg_err, pif.win_rd_en});
    else passes++;
    step();
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    int nw = 0;
    int done_k = -1;
    launch(1'b0, 8'd4, 8'd4, 8'd1);
    step();
    step();
    checks++;
    if ({pif.win_rd_en, pif.win_row, pif.win_col} !== {1'b1, 8'd2, 8'd0})
      $display("FAIL rstmid_win3 got en=%b (%0d,%0d) want 1 (2,0)", pif.win_rd_en,
               pif.win_row, pif.win_col);
    else passes++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, cfg_err, pif.win_rd_en, in_pipe_en, out_pipe_en, pif.wr_valid, ctrl_pool}
        !== 8'b0000_0001)
      $display("FAIL rstmid_outs got %b want 00000001", {busy, done, cfg_err, pif.win_rd_en,
               in_pipe_en, out_pipe_en, pif.wr_valid, ctrl_pool});
    else passes++;
    checks++;
    if ({pif.wr_addr, pif.win_row, pif.win_col, pif.win_grp} !== {ADDR_W'(0), 24'd0})
      $display("FAIL rstmid_addr got %0d row=%0d col=%0d want 0", pif.wr_addr, pif.win_row,
               pif.win_col);
    else passes++;
    for (int k = 0; k < 6; k++) begin
      if (done || pif.wr_valid) stray++;
      step();
    end
    checks++;
    if (stray !== 0) $display("FAIL rstmid_abort got %0d stray cycles want 0", stray);
    else passes++;
    launch(1'b1, 8'd4, 8'd4, 8'd1);
    for (int k = 1; k <= 10; k++) begin
      if (pif.wr_valid) begin
        checks++;
        if (pif.wr_addr !== ADDR_W'(nw)) $display("FAIL rstmid_seq got %0d want %0d", pif.wr_addr, nw);
        else passes++;
        nw++;
      end
      if (done) done_k = k;
      step();
    end
    checks++;
    if ({nw, done_k} !== {32'd4, 32'd8})
      $display("FAIL rstmid_job got writes=%0d done=%0d want 4 8", nw, done_k);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int nw = 0;
    int done_k = -1;
    launch(1'b1, 8'd4, 8'd4, 8'd1);
    for (int k = 1; k <= 9; k++) begin
      start = 1'b0;
      if (k == 3) begin
        start = 1'b1; map_w = 8'd6; num_groups = 8'd2;
      end
      if (pif.wr_valid && pif.wr_ready) nw++;
      if (done) done_k = k;
      if (k == 9) begin
        start = 1'b1; map_w = 8'd6; map_h = 8'd4; num_groups = 8'd1;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if ({nw, done_k} !== {32'd4, 32'd8})
      $display("FAIL b2b_job1 got writes=%0d done=%0d want 4 8", nw, done_k);
    else passes++;
    nw = 0;
    done_k = -1;
    for (int j = 1; j <= 12; j++) begin
      if (j == 1) begin
        checks++;
        if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy);
        else passes++;
      end
      if (pif.wr_valid) begin
        checks++;
        if (pif.wr_addr !== ADDR_W'(nw)) $display("FAIL b2b_seq got %0d want %0d", pif.wr_addr, nw);
        else passes++;
        nw++;
      end
      if (done) done_k = j;
      step();
    end
    checks++;
    if ({nw, done_k} !== {32'd6, 32'd10})
      $display("FAIL b2b_job2 got writes=%0d done=%0d want 6 10", nw, done_k);
    else passes++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b1;
    map_w = 8'd4; map_h = 8'd4; num_groups = 8'd1;
    pif.wr_ready = 1'b1;
    test_reset();
    test_basic();
    test_mode_latch();
    test_stall();
    test_cfg_err();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
